// File: rtl/snx_dmem_pkg.sv
// Shared types and defaults for the SNX dmem arbiter: FSM states,
// requester ids and the I/O decode / LED reset defaults.
package snx_dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DBG = 1'b1
  } req_id_e;

  localparam int         IO_BIT_DEF   = 15;
  localparam logic [7:0] LED_INIT_DEF = 8'h00;

endpackage

// File: rtl/snx_dmem_arbiter_if.sv
// Bus bundle between the two requesters (CPU data port, debug/loader port),
// the arbiter and the dmem SRAM macro.
interface snx_dmem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 16
) ();

  logic          cpu_rd;
  logic          cpu_wr;
  logic [15:0]   cpu_adrs;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          cpu_wait;

  logic          dbg_req;
  logic          dbg_we;
  logic [15:0]   dbg_adrs;
  logic [DW-1:0] dbg_wdata;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ack;

  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_adrs;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // arbiter side
  modport slave (
    input  cpu_rd, cpu_wr, cpu_adrs, cpu_wdata,
    input  dbg_req, dbg_we, dbg_adrs, dbg_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_wait,
    output dbg_rdata, dbg_ack,
    output mem_cs, mem_we, mem_adrs, mem_wdata
  );

  // requester / memory side
  modport master (
    output cpu_rd, cpu_wr, cpu_adrs, cpu_wdata,
    output dbg_req, dbg_we, dbg_adrs, dbg_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_wait,
    input  dbg_rdata, dbg_ack,
    input  mem_cs, mem_we, mem_adrs, mem_wdata
  );

endinterface

// File: rtl/snx_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 = CPU, bit 1 = DBG.
// The last-grant flop resets to DBG so the CPU wins the first contention.
module snx_rr_arb2
  import snx_dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic       last_dbg_reg;
  logic [1:0] prio;

  // a side has priority when the other one was served last
  assign prio = {~last_dbg_reg, last_dbg_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt[gi] = req[gi] & (~req[1-gi] | prio[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dbg_reg <= 1'b1;
    end else if (update) begin
      last_dbg_reg <= gnt[REQ_DBG];
    end
  end

endmodule

// File: rtl/snx_dmem_arbiter.sv
// Shares the single-port dmem between the CPU and the debug port, decodes
// the I/O region (switch read / LED write), three-cycle access per request.
module snx_dmem_arbiter
  import snx_dmem_pkg::*;
#(
  parameter int         AW       = 10,
  parameter int         DW       = 16,
  parameter int         IO_BIT   = IO_BIT_DEF,
  parameter logic [7:0] LED_INIT = LED_INIT_DEF
) (
  input  logic                m_clock,
  input  logic                p_reset,
  snx_dmem_arbiter_if.slave   bus,
  input  logic [7:0]          sw,
  output logic [7:0]          led,
  output logic                err
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] ACC  = ST_ACC;
  localparam logic [1:0] RESP = ST_RESP;

  logic [1:0]    state_reg;
  logic          sel_dbg_reg;
  logic          write_reg;
  logic          io_reg;
  logic [7:0]    io_rdata_reg;

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          accept;
  logic          sel_dbg;
  logic          io_sel;
  logic          write_sel;
  logic [AW-1:0] madrs_sel;
  logic [DW-1:0] wdata_sel;
  logic          unused_adrs_bits;

  assign req    = {bus.dbg_req, bus.cpu_rd | bus.cpu_wr};
  assign accept = (state_reg == IDLE) && (gnt != 2'b00);

  snx_rr_arb2 u_arb (
    .clk    (m_clock),
    .rst_n  (p_reset),
    .req    (req),
    .update (accept),
    .gnt    (gnt)
  );

  // cpu_rd & cpu_wr together resolves to a write
  assign sel_dbg   = gnt[REQ_DBG];
  assign io_sel    = sel_dbg ? bus.dbg_adrs[IO_BIT]   : bus.cpu_adrs[IO_BIT];
  assign write_sel = sel_dbg ? bus.dbg_we             : bus.cpu_wr;
  assign madrs_sel = sel_dbg ? bus.dbg_adrs[AW-1:0]   : bus.cpu_adrs[AW-1:0];
  assign wdata_sel = sel_dbg ? bus.dbg_wdata          : bus.cpu_wdata;

  // upper address bits alias inside the memory region
  assign unused_adrs_bits = ^{bus.cpu_adrs[IO_BIT-1:AW], bus.dbg_adrs[IO_BIT-1:AW]};

  assign bus.cpu_wait = (bus.cpu_rd | bus.cpu_wr) & ~bus.cpu_ack;

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state_reg     <= IDLE;
      sel_dbg_reg   <= 1'b0;
      write_reg     <= 1'b0;
      io_reg        <= 1'b0;
      io_rdata_reg  <= 8'h00;
      bus.cpu_ack   <= 1'b0;
      bus.dbg_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.dbg_rdata <= '0;
      bus.mem_cs    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_adrs  <= '0;
      bus.mem_wdata <= '0;
      led           <= LED_INIT;
      err           <= 1'b0;
    end else begin
      bus.cpu_ack <= 1'b0;
      bus.dbg_ack <= 1'b0;
      bus.mem_cs  <= 1'b0;
      bus.mem_we  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            sel_dbg_reg   <= sel_dbg;
            write_reg     <= write_sel;
            io_reg        <= io_sel;
            bus.mem_cs    <= ~io_sel;
            bus.mem_we    <= write_sel & ~io_sel;
            bus.mem_adrs  <= madrs_sel;
            bus.mem_wdata <= wdata_sel;
            if (!sel_dbg && bus.cpu_rd && bus.cpu_wr) begin
              err <= 1'b1;
            end
            state_reg <= ACC;
          end
        end
        ACC: begin
          if (io_reg) begin
            if (write_reg) begin
              led <= bus.mem_wdata[7:0];
            end else begin
              io_rdata_reg <= sw;
            end
          end
          state_reg <= RESP;
        end
        RESP: begin
          if (sel_dbg_reg) begin
            bus.dbg_ack <= 1'b1;
            if (!write_reg) begin
              bus.dbg_rdata <= io_reg ? DW'({8'h00, io_rdata_reg}) : bus.mem_rdata;
            end
          end else begin
            bus.cpu_ack <= 1'b1;
            if (!write_reg) begin
              bus.cpu_rdata <= io_reg ? DW'({8'h00, io_rdata_reg}) : bus.mem_rdata;
            end
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/snx_dmem_arbiter.md
Name: snx_dmem_arbiter

Overview:
- Shares the single-port synchronous SNX data memory between two requesters: the CPU data port and a debug/loader port used to preload or dump dmem.
- Decodes the memory-mapped I/O region at adrs[IO_BIT]=1: reads return the 8-bit switch input, writes update the 8-bit LED register.
- Round-robin arbitration with a request/acknowledge handshake, and a fixed 3-cycle access sequence per transaction.
- Sits between the snx core and the dmem SRAM macro.

Parameters:
- AW, 10: dmem word-address width (1024 words).
- DW, 16: data width.
- IO_BIT, 15: address bit that selects the I/O region.
- LED_INIT, 8'h00: reset value of the LED register.

Ports:
- m_clock  in  1  system clock, rising-edge.
- p_reset  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  CPU read request; held until cpu_ack.
- cpu_wr  in  1  CPU write request; held until cpu_ack.
- cpu_adrs  in  16  CPU word address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rdata  out  DW  CPU read data; valid while cpu_ack=1, held afterwards.
- cpu_ack  out  1  one-cycle completion pulse to the CPU.
- cpu_wait  out  1  CPU stall indication.
- dbg_req  in  1  debug request; held until dbg_ack.
- dbg_we  in  1  debug write enable (1=write, 0=read).
- dbg_adrs  in  16  debug word address.
- dbg_wdata  in  DW  debug write data.
- dbg_rdata  out  DW  debug read data; valid while dbg_ack=1.
- dbg_ack  out  1  one-cycle completion pulse to the debug port.
- mem_cs  out  1  SRAM chip select.
- mem_we  out  1  SRAM write enable.
- mem_adrs  out  AW  SRAM address.
- mem_wdata  out  DW  SRAM write data.
- mem_rdata  in  DW  SRAM read data; valid one cycle after a cs & !we cycle.
- sw  in  8  switch input.
- led  out  8  LED register.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (p_reset=0, asynchronous): the following are cleared to 0:
  - state = IDLE
  - cpu_ack, dbg_ack, mem_cs, mem_we
  - cpu_rdata, dbg_rdata, mem_adrs, mem_wdata, err
  - led = LED_INIT
  - last-grant = DBG, so the CPU wins the first contention.
- FSM states: IDLE, ACC, RESP.
- IDLE:
  - Sample the requests. CPU request = cpu_rd|cpu_wr.
  - If only one side requests, grant it.
  - If both request, grant the side not equal to last-grant.
  - Latch grant, address, wdata and direction, then go to ACC. With no request, stay in IDLE.
- ACC (one cycle):
  - Memory region: mem_cs=1, mem_we=write, mem_adrs=adrs[AW-1:0], mem_wdata=wdata.
  - I/O region: mem_cs=0. A write loads led <= wdata[7:0] at the end of ACC. A read captures {8'h00, sw}.
  - Go to RESP.
- RESP (one cycle):
  - mem_cs=0.
  - The granted side's ack=1.
  - For a read, the granted side's rdata <= mem_rdata (memory) or the captured I/O value.
  - Update last-grant, then go to IDLE.
- Latency and throughput: a request sampled at edge k is acked in the cycle after edge k+2. Maximum throughput is one access per 3 cycles.
- cpu_wait = (cpu_rd|cpu_wr) & !cpu_ack, combinational.
- Address rules:
  - Bits [IO_BIT-1:AW] are ignored in the memory region, so those addresses alias (wrap).
  - In the I/O region, all bits other than IO_BIT are ignored.
- cpu_rd & cpu_wr both high when sampled: treated as a write, and err is set. err is cleared only by reset.
- Dropping a request before its ack is illegal. The arbiter still completes the latched transaction and pulses ack.
- The write data path never modifies rdata outputs.
- Reset during ACC or RESP: the transaction is abandoned, no ack is issued, and an in-flight LED write is lost.

Decomposition:
- Package snx_dmem_pkg holds:
  - state enum {IDLE, ACC, RESP}
  - requester id enum {REQ_CPU, REQ_DBG}
  - IO_BIT default
  - LED_INIT default
- Sub-module snx_rr_arb2: two-request round-robin arbiter holding the last-grant flop, with inputs req[1:0] and update, and outputs gnt[1:0] (one-hot).

Test Plan:
- Reset: hold p_reset=0 -> led=00, err=0, all acks/cs=0. Release; with no requests, mem_cs stays 0 for 10 cycles.
- CPU read: preload dmem[5]=1234; cpu_rd, adrs=0005 -> mem_cs=1 and mem_we=0 one cycle after sampling; cpu_ack with cpu_rdata=1234 two cycles after sampling; cpu_wait high until ack.
- Contention: cpu_rd and dbg_req rise together after reset -> CPU served first, then DBG. Repeat with both still held -> grants alternate CPU, DBG, CPU.
- I/O access:
  - cpu_wr adrs=8000, wdata=00A5 -> led=A5, mem_cs never asserted.
  - cpu_rd adrs=8003 with sw=34 -> cpu_rdata=0034.
- Aliasing/error:
  - dbg write adrs=0405, data=BEEF -> mem_adrs=005.
  - cpu_rd & cpu_wr together -> write performed, err=1 and stays 1 until reset.
- Mid-op reset: assert p_reset=0 during ACC of a led write (wdata=00FF) -> led=00, no ack. After release, the next CPU request completes normally.
